// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 16-bit pipeline: load-use, branch squash, memory wait with watchdog, halt.
// Optional stall statistics counter is built only when PIPE_CTRL_STATS_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              halt_req,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic              timeout_err,
    output logic [15:0]       stall_cnt
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          load_use;
    logic          run_eval;
    logic          miss_allowed;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        run_eval     = 1'b0;
        miss_allowed = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_eval     = 1'b1;
                miss_allowed = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    // Ack cycle behaves like RUN, minus the miss term.
                    run_eval = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_eval) begin
            if (halt_req) begin
                state_d = ST_HALT;
            end else if (miss_allowed && mem_req && !mem_ack) begin
                state_d    = ST_MEM_WAIT;
                wait_cnt_d = '0;
            end else if (ex_branch_taken) begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                idex_we    = 1'b1;
                exmem_we   = 1'b1;
                memwb_we   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_we    = 1'b1;
                idex_flush = 1'b1;
                exmem_we   = 1'b1;
                memwb_we   = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                memwb_we = 1'b1;
            end
        end

        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences and random stimulus vs. a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;
    localparam int TMO = 4;

    // Output pattern: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    localparam logic [7:0] P_ALL_ON = 8'b11111_00_0;
    localparam logic [7:0] P_FROZEN = 8'b00000_00_0;
    localparam logic [7:0] P_SQUASH = 8'b11111_11_0;
    localparam logic [7:0] P_BUBBLE = 8'b00111_01_0;
    localparam logic [7:0] P_RESET  = 8'b00000_11_0;
    localparam logic [7:0] P_HALTED = 8'b00000_00_1;

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          uses;
        logic [AW-1:0] rd;
        logic          mrd;
        logic          br;
        logic          mreq;
        logic          ack;
        logic          halt;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ack, halt_req;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, halted, timeout_err;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model: what the pipeline is doing, not how the controller encodes it.
    bit m_known = 0;
    bit m_halted = 0;
    bit m_waiting = 0;
    int m_waited = 0;
    bit m_terr = 0;
    int m_stalls = 0;

    function automatic in_t mk(input logic r, input int rs1, input int rs2, input logic uses,
                               input int rd, input logic mrd, input logic br,
                               input logic mreq, input logic ack, input logic halt);
        in_t v;
        v.rst = r; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.uses = uses; v.rd = AW'(rd);
        v.mrd = mrd; v.br = br; v.mreq = mreq; v.ack = ack; v.halt = halt;
        return v;
    endfunction

    function automatic logic [7:0] model_out(input in_t v);
        bit dep;
        dep = v.mrd && (v.rd != 0) && ((v.rd == v.rs1) || (v.uses && (v.rd == v.rs2)));
        if (v.rst) return P_RESET;
        if (m_halted) return P_HALTED;
        if (m_waiting && !v.ack) return P_FROZEN;
        if (v.halt) return P_FROZEN;
        if (!m_waiting && v.mreq && !v.ack) return P_FROZEN;
        if (v.br) return P_SQUASH;
        if (dep) return P_BUBBLE;
        return P_ALL_ON;
    endfunction

    task automatic model_adv(input in_t v, input logic [7:0] exp);
        if (v.rst) begin
            m_known = 1; m_halted = 0; m_waiting = 0; m_waited = 0; m_terr = 0; m_stalls = 0;
        end else if (!m_halted) begin
            if (!exp[7] && m_stalls < 65535) m_stalls++;
            if (m_waiting && !v.ack) begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_halted = 1; m_terr = 1; m_waiting = 0;
                end
            end else if (v.halt) begin
                m_halted = 1; m_waiting = 0;
            end else if (!m_waiting && v.mreq && !v.ack) begin
                m_waiting = 1; m_waited = 0;
            end else begin
                m_waiting = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic run_cycle(input in_t v, input string name, input logic use_exp, input logic [7:0] exp);
        logic [7:0] got, mexp;
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses; ex_rd = v.rd;
        ex_mem_read = v.mrd; ex_branch_taken = v.br; mem_req = v.mreq; mem_ack = v.ack; halt_req = v.halt;
        #4;
        got = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, halted};
        mexp = model_out(v);
        if (use_exp) check({name, "_tbl"}, 16'(got), 16'(exp));
        check({name, "_out"}, 16'(got), 16'(mexp));
        if (m_known) begin
            check({name, "_terr"}, 16'(timeout_err), 16'(m_terr));
`ifdef PIPE_CTRL_STATS_EN
            check({name, "_stall"}, stall_cnt, 16'(m_stalls));
`else
            check({name, "_stall"}, stall_cnt, 16'h0000);
`endif
        end
        $display("cycle %-12s in=%h out=%b terr=%b stall=%0d", name, v, got, timeout_err, stall_cnt);
        @(posedge clk);
        model_adv(v, mexp);
        #1;
    endtask

    in_t idle, rst_v, miss, wait0, ack_v;
    vec_t table_v[$];
    int stall_before;

    initial begin
        idle  = mk(0, 1, 2, 1, 5, 0, 0, 0, 0, 0);
        rst_v = mk(1, 1, 2, 1, 5, 0, 0, 0, 0, 0);
        miss  = mk(0, 1, 2, 1, 5, 0, 0, 1, 0, 0);
        ack_v = mk(0, 1, 2, 1, 5, 0, 0, 1, 1, 0);
        wait0 = miss;

        table_v.push_back('{"idle",      idle,                              P_ALL_ON});
        table_v.push_back('{"lu_rs1",    mk(0, 3, 7, 0, 3, 1, 0, 0, 0, 0),  P_BUBBLE});
        table_v.push_back('{"lu_rd0",    mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0),  P_ALL_ON});
        table_v.push_back('{"lu_rs2",    mk(0, 1, 9, 1, 9, 1, 0, 0, 0, 0),  P_BUBBLE});
        table_v.push_back('{"rs2_unused",mk(0, 1, 9, 0, 9, 1, 0, 0, 0, 0),  P_ALL_ON});
        table_v.push_back('{"no_load",   mk(0, 3, 3, 1, 3, 0, 0, 0, 0, 0),  P_ALL_ON});
        table_v.push_back('{"br_beats_lu",mk(0, 3, 7, 0, 3, 1, 1, 0, 0, 0), P_SQUASH});
        table_v.push_back('{"branch",    mk(0, 1, 2, 1, 5, 0, 1, 0, 0, 0),  P_SQUASH});
        table_v.push_back('{"req_ack",   ack_v,                             P_ALL_ON});
        table_v.push_back('{"lu_rd15",   mk(0, 15, 2, 0, 15, 1, 0, 0, 0, 0),P_BUBBLE});

        // Reset for two cycles, then a clean RUN cycle.
        run_cycle(rst_v, "reset0", 1, P_RESET);
        run_cycle(rst_v, "reset1", 1, P_RESET);
        run_cycle(idle, "post_rst", 1, P_ALL_ON);

        foreach (table_v[i]) run_cycle(table_v[i].in, table_v[i].name, 1, table_v[i].exp);

        // Memory miss acked on the third cycle after entry.
        stall_before = m_stalls;
        run_cycle(miss,  "miss_n",   1, P_FROZEN);
        run_cycle(wait0, "wait_1",   1, P_FROZEN);
        run_cycle(wait0, "wait_2",   1, P_FROZEN);
        run_cycle(ack_v, "ack_3",    1, P_ALL_ON);
        run_cycle(idle,  "after_ack",1, P_ALL_ON);
`ifdef PIPE_CTRL_STATS_EN
        check("memwait_stalls", 16'(m_stalls - stall_before), 16'd3);
`endif

        // Watchdog: no ack ever.
        run_cycle(miss,  "wd_n",  1, P_FROZEN);
        for (int k = 1; k <= TMO; k++) run_cycle(wait0, $sformatf("wd_w%0d", k), 1, P_FROZEN);
        check("wd_terr_model", 16'(m_terr), 16'd1);
        run_cycle(wait0, "wd_halted", 1, P_HALTED);
        run_cycle(mk(0, 1, 2, 1, 5, 0, 1, 0, 0, 0), "wd_br_halt", 1, P_HALTED);
        run_cycle(rst_v, "wd_rst", 1, P_RESET);
        run_cycle(idle,  "wd_clear", 1, P_ALL_ON);

        // Halt request and attempted branch while halted.
        run_cycle(mk(0, 1, 2, 1, 5, 0, 1, 0, 0, 1), "halt_req", 1, P_FROZEN);
        run_cycle(idle, "halted", 1, P_HALTED);
        run_cycle(mk(0, 1, 2, 1, 5, 0, 1, 0, 0, 0), "halt_br", 1, P_HALTED);
        run_cycle(rst_v, "halt_rst", 1, P_RESET);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            v.rst  = m_halted ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
            v.rs1  = AW'($urandom_range(3));
            v.rs2  = AW'($urandom_range(3));
            v.uses = 1'($urandom);
            v.rd   = AW'($urandom_range(3));
            v.mrd  = 1'($urandom);
            v.br   = ($urandom_range(5) == 0);
            v.mreq = ($urandom_range(3) == 0);
            v.ack  = 1'($urandom);
            v.halt = m_waiting ? 1'b0 : ($urandom_range(31) == 0);
            run_cycle(v, $sformatf("rnd%0d", n), 0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush controller for the 16-bit pipelined datapath. Drives the write enables and bubble-insert flushes of the four inter-stage `buffer` registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. Resolves, per cycle:
- load-use hazards,
- taken-branch squashes,
- multi-cycle memory waits with a watchdog,
- program halt.

## Interface
- `REG_AW`, 4, register-address width of rs/rd fields
- `MEM_TIMEOUT`, 8, max consecutive MEM_WAIT cycles without ack before fault (>=1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_rs1`  in  REG_AW  source reg 1 of instr in ID
- `id_rs2`  in  REG_AW  source reg 2 of instr in ID
- `id_uses_rs2`  in  1  ID instr reads rs2
- `ex_rd`  in  REG_AW  dest reg of instr in EX
- `ex_mem_read`  in  1  EX instr is a load
- `ex_branch_taken`  in  1  EX resolved a taken branch/jump
- `mem_req`  in  1  MEM stage holds an access awaiting ack
- `mem_ack`  in  1  memory completes access this cycle
- `halt_req`  in  1  HALT instr in WB
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we`  out  1 each  load enables for PC and stage buffers
- `ifid_flush`, `idex_flush`  out  1 each  load all-zero bubble into that buffer
- `halted`  out  1  controller in HALT
- `timeout_err`  out  1  sticky watchdog fault
- `stall_cnt`  out  16  stall statistics (see Configuration)

## Operation
- Registered state: RUN, MEM_WAIT, HALT. Registered watchdog counter `wait_cnt`, width clog2(MEM_TIMEOUT+1).
- All enable/flush outputs are combinational from state and current inputs.
- rst=1 (any state, overrides everything):
  - outputs: all `*_we`=0, both flushes=1, `halted`=0.
  - next cycle: state RUN, `wait_cnt`=0, `timeout_err`=0, `stall_cnt`=0.
- RUN, evaluated in this priority order:
  1. `halt_req`: all `*_we`=0, flushes=0; next HALT.
  2. `mem_req & !mem_ack`: all `*_we`=0; next MEM_WAIT; `wait_cnt`<=0.
  3. `ex_branch_taken`: all `*_we`=1, `ifid_flush`=1, `idex_flush`=1 (squash two wrong-path instrs). Branch overrides load-use.
  4. Load-use, i.e. `ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))`:
     - `pc_we`=0, `ifid_we`=0 (hold fetch/decode).
     - `idex_we`=1 with `idex_flush`=1 (bubble).
     - `exmem_we`=`memwb_we`=1.
     - Stays RUN; the hazard clears next cycle because EX then holds the bubble.
  5. Otherwise: all `*_we`=1, flushes=0.
- Register 0 never causes a load-use stall.
- MEM_WAIT:
  - `mem_ack`=0: all `*_we`=0, flushes=0, `wait_cnt`++. If `wait_cnt`==MEM_TIMEOUT-1 this cycle, next state HALT and `timeout_err`<=1.
  - `mem_ack`=1: the cycle is evaluated by RUN rules with term 2 forced false; next state is per those rules, RUN if none apply.
  - `halt_req` is ignored in MEM_WAIT; WB is frozen there.
- HALT:
  - all `*_we`=0, flushes=0, `halted`=1.
  - Only rst exits HALT. `timeout_err` holds until rst.
- Flush is meaningful only with the matching `*_we`=1. The controller never asserts a flush with its enable low, except during reset.

## Timing
- Zero-cycle latency from hazard inputs to enables and flushes; buffers capture on the same rising edge.
- Load-use: exactly 1 stall cycle per hazard.
- Taken branch: 2-instruction penalty, 0 stall cycles.
- Memory miss entered at cycle N, ack at cycle N+k (k>=1, k<=MEM_TIMEOUT): enables are low for cycles N..N+k-1 and high at N+k.
- No ack: enables stay low for cycles N..N+MEM_TIMEOUT. `halted`=1 and `timeout_err`=1 from cycle N+MEM_TIMEOUT+1.
- `mem_req & mem_ack` in the same RUN cycle: no stall.
- rst asserted mid-MEM_WAIT or mid-HALT: takes effect on the next edge, all state cleared.

## Configuration
- `PIPE_CTRL_STATS_EN` defined:
  - `stall_cnt` increments on every non-reset cycle where `pc_we`=0 and state is not HALT. This includes the halt_req cycle and load-use/MEM_WAIT cycles.
  - Saturates at 16'hFFFF; cleared by rst.
- Not defined: `stall_cnt` is constant 16'h0000 and no counter logic is built.

## Test plan
- Reset: rst=1 for 2 cycles -> all `*_we`=0, flushes=1. After release with no hazards -> all `*_we`=1, `halted`=0, `timeout_err`=0.
- Load-use: `ex_mem_read`=1, `ex_rd`=3, `id_rs1`=3 for 1 cycle -> `pc_we`=`ifid_we`=0, `idex_flush`=1, `exmem_we`=1. Repeat with `ex_rd`=0 -> no stall.
- Branch beats load-use: `ex_branch_taken`=1 plus the load-use condition above -> all `*_we`=1, `ifid_flush`=`idex_flush`=1.
- Memory wait, MEM_TIMEOUT=4: `mem_req`=1, `mem_ack` high 3 cycles later -> enables low for 3 cycles, high on the ack cycle, state RUN. With stats enabled, `stall_cnt`=3.
- Watchdog, MEM_TIMEOUT=4: `mem_req`=1, `mem_ack`=0 forever -> 5 stalled cycles, then `halted`=1, `timeout_err`=1. Pulse rst -> both clear, RUN.
- Halt: `halt_req`=1 for 1 cycle in RUN -> all `*_we`=0 that cycle and `halted`=1 thereafter. `ex_branch_taken`=1 while halted -> no enables.
